// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an active-low 8:1 mux: steps sel through 0..7, samples after settling, offers an 8-bit frame.
// Optional SCAN_AUTO_EN: free-running scans; start_i is ignored.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic [2:0] sel_o,
    input  logic       mux_y_n_i,
    output logic       busy_o,
    output logic [7:0] frame_o,
    output logic       frame_valid_o,
    input  logic       frame_ready_i
);

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned FRAME_W = 8;
    localparam int unsigned CNT_W   = 8;

    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] cap_q, cap_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               scan_go_c;

`ifdef SCAN_AUTO_EN
    logic unused_start;
    assign unused_start = start_i;
    assign scan_go_c    = 1'b1;
`else
    assign scan_go_c    = start_i;
`endif

    // State and output registers; reset discards any partial scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath; sel only moves outside the sampling cycle.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        frame_d = frame_q;
        valid_d = valid_q;

        case (state_q)
            S_IDLE: begin
                if (scan_go_c) begin
                    state_d = S_SETTLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                cap_d[sel_q] = ~mux_y_n_i;
                if (sel_q == LAST_SEL) begin
                    state_d = S_HOLD;
                    frame_d = cap_d;
                    valid_d = 1'b1;
                end else begin
                    state_d = S_SETTLE;
                    sel_d   = sel_q + SEL_W'(1);
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (valid_q && frame_ready_i) begin
                    valid_d = 1'b0;
                    sel_d   = '0;
`ifdef SCAN_AUTO_EN
                    state_d = S_SETTLE;
                    cnt_d   = '0;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign sel_o         = sel_q;
    assign busy_o        = busy_q;
    assign frame_o       = frame_q;
    assign frame_valid_o = valid_q;

endmodule
